riv_timer_arbiter: RTL and testbench

RIV_TIMER_ARBITER -- requirements
Module: riv_timer_arbiter

---
 rtl/riv_timer_arbiter_pkg.sv | 16 +
 rtl/riv_counter.sv | 27 ++
 rtl/riv_timer_arbiter.sv | 136 +++++++++++++
 tb/tb_riv_timer_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riv_timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin timer arbiter.
package riv_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        EXPIRE = 2'd3
    } arb_state_t;

    // Index that follows idx in a ring of n_req requesters.
    function automatic int rr_next(input int idx, input int n_req);
        return (idx + 1 >= n_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/riv_counter.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module riv_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/riv_timer_arbiter.sv
// Time-shares one interval counter among N_REQ requesters, one timer at a time,
// picking owners round-robin and reporting grant/expire pulses per requester.
module riv_timer_arbiter
    import riv_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     req_value,
    input  logic [N_REQ-1:0]           cancel,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           expire,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [1:0]                 dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr, rr_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  own_mask;
    logic              own_cancel;
    logic              cnt_load, cnt_en, cnt_done;

    // First requesting index at or after ptr, walking the ring upward.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] rot;
        int               s;
        rr_pick = ptr;
        s       = 0;
        rot     = N_REQ'({r, r} >> ptr);
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = int'(ptr) + k;
                if (s >= N_REQ) s = s - N_REQ;
                rr_pick = IDX_W'(s);
            end
        end
    endfunction

    assign pick_idx   = rr_pick(req, rr_ptr);
    assign own_mask   = N_REQ'(1) << owner_q;
    assign own_cancel = |(cancel & own_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_ptr  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_ptr  <= rr_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_ptr;
        value_d  = value_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        grant    = '0;
        expire   = '0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick_idx;
                    value_d = req_value[int'(pick_idx)*WIDTH +: WIDTH];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                grant    = own_mask;
                if (own_cancel) begin
                    rr_d    = IDX_W'(rr_next(int'(owner_q), N_REQ));
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_en = !cnt_done;
                // A cancel beats a simultaneous done so no expire escapes.
                if (own_cancel) begin
                    rr_d    = IDX_W'(rr_next(int'(owner_q), N_REQ));
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = EXPIRE;
                end
            end
            EXPIRE: begin
                expire  = own_mask;
                rr_d    = IDX_W'(rr_next(int'(owner_q), N_REQ));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep every visible strobe quiet while reset is being applied.
        if (!rst_n) begin
            cnt_load = 1'b0;
            cnt_en   = 1'b0;
            grant    = '0;
            expire   = '0;
            busy     = 1'b0;
        end
    end

    riv_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .enable     (cnt_en),
        .load_value (value_q),
        .done       (cnt_done)
    );

    assign owner     = owner_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_riv_timer_arbiter.sv
// Directed bench for riv_timer_arbiter: timing, round-robin order, cancel and reset.
module tb_riv_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_RUN  = 32'd2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req = '0;
    logic [N*W-1:0]     req_value = '0;
    logic [N-1:0]       cancel = '0;
    logic [N-1:0]       grant;
    logic [N-1:0]       expire;
    logic               busy;
    logic [1:0]         owner;
    logic [1:0]         dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riv_timer_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_value (req_value),
        .cancel    (cancel),
        .grant     (grant),
        .expire    (expire),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("quiet_grant", 32'(grant), 32'd0);
            chk("quiet_expire", 32'(expire), 32'd0);
        end
    endtask

    task automatic set_val(input int i, input logic [W-1:0] v);
        req_value[i*W +: W] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_expire", 32'(expire), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_state", 32'(dbg_state), S_IDLE);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // All four requesting, value 2: grants 0,1,2,3,0; expire 4 cycles after grant
        for (int i = 0; i < N; i++) set_val(i, 16'd2);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", 32'(grant), 32'd1 << (k % N));
            chk("rr_owner", 32'(owner), 32'(k % N));
            quiet(3);
            step();
            chk("rr_expire", 32'(expire), 32'd1 << (k % N));
            chk("rr_exp_nogrant", 32'(grant), 32'd0);
            if (k == 4) req = '0;
            step();
            chk("rr_idle", 32'(busy), 32'd0);
        end

        // req[0], value 5: grant at 1, expire at 8, idle at 9
        set_val(0, 16'd5);
        req = 4'b0001;
        step();
        chk("v5_grant", 32'(grant), 32'b0001);
        chk("v5_busy", 32'(busy), 32'd1);
        chk("v5_owner", 32'(owner), 32'd0);
        req = '0;
        quiet(6);
        step();
        chk("v5_expire", 32'(expire), 32'b0001);
        step();
        chk("v5_idle", 32'(busy), 32'd0);
        chk("v5_noexp", 32'(expire), 32'd0);

        // req[2], value 0: grant at 1, expire at 3
        set_val(2, 16'd0);
        req = 4'b0100;
        step();
        chk("v0_grant", 32'(grant), 32'b0100);
        req = '0;
        quiet(1);
        step();
        chk("v0_expire", 32'(expire), 32'b0100);
        step();
        chk("v0_idle", 32'(busy), 32'd0);

        // Owner cancel in the same cycle as done: no expire
        set_val(3, 16'd3);
        req = 4'b1000;
        step();
        chk("cd_grant", 32'(grant), 32'b1000);
        req = '0;
        quiet(3);
        step();
        chk("cd_run", 32'(dbg_state), S_RUN);
        cancel = 4'b1000;
        step();
        cancel = '0;
        chk("cd_noexp", 32'(expire), 32'd0);
        chk("cd_idle", 32'(dbg_state), S_IDLE);
        chk("cd_busy", 32'(busy), 32'd0);

        // Non-owner cancels during LOAD and RUN: expire on time
        set_val(0, 16'd3);
        req = 4'b0001;
        step();
        chk("nc_grant", 32'(grant), 32'b0001);
        req = '0;
        cancel = 4'b1110;
        quiet(4);
        cancel = '0;
        step();
        chk("nc_expire", 32'(expire), 32'b0001);
        step();
        chk("nc_idle", 32'(busy), 32'd0);

        // req[1], value 100, cancel at cycle 10: idle at 11, next grant to 2
        set_val(1, 16'd100);
        req = 4'b0010;
        step();
        chk("cx_grant", 32'(grant), 32'b0010);
        chk("cx_owner", 32'(owner), 32'd1);
        set_val(0, 16'd1);
        set_val(2, 16'd1);
        req = 4'b0101;
        quiet(9);
        chk("cx_busy", 32'(busy), 32'd1);
        cancel = 4'b0010;
        step();
        cancel = '0;
        chk("cx_idle", 32'(dbg_state), S_IDLE);
        chk("cx_noexp", 32'(expire), 32'd0);
        step();
        chk("cx_next_grant", 32'(grant), 32'b0100);
        chk("cx_next_owner", 32'(owner), 32'd2);
        req = '0;
        quiet(2);
        step();
        chk("cx_next_expire", 32'(expire), 32'b0100);
        step();
        chk("cx_done_idle", 32'(busy), 32'd0);

        // Reset mid-RUN: silent abandon, pointer back to 0
        set_val(2, 16'd50);
        req = 4'b0100;
        step();
        chk("rs_grant", 32'(grant), 32'b0100);
        req = '0;
        quiet(2);
        step();
        chk("rs_run", 32'(dbg_state), S_RUN);
        rst_n = 1'b0;
        #1;
        chk("rs_in_grant", 32'(grant), 32'd0);
        chk("rs_in_busy", 32'(busy), 32'd0);
        chk("rs_in_expire", 32'(expire), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rs_post_busy", 32'(busy), 32'd0);
        chk("rs_post_state", 32'(dbg_state), S_IDLE);
        chk("rs_post_owner", 32'(owner), 32'd0);
        chk("rs_post_grant", 32'(grant), 32'd0);
        chk("rs_post_expire", 32'(expire), 32'd0);
        set_val(0, 16'd0);
        step();
        chk("rs_still_idle", 32'(busy), 32'd0);
        req = 4'b1111;
        step();
        chk("rs_new_grant", 32'(grant), 32'b0001);
        chk("rs_new_owner", 32'(owner), 32'd0);
        req = '0;
        quiet(1);
        step();
        chk("rs_new_expire", 32'(expire), 32'b0001);
        step();
        chk("rs_final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
